// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the alu execute stage.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_MOD = 4'h3,
        OP_DIV = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_XOR = 4'h7,
        OP_SHL = 4'h8,
        OP_SHR = 4'h9
    } op_e;

    localparam logic [3:0] OP_LAST_VALID = 4'h9;

    // Encodings above OP_LAST_VALID are reserved and always flagged as errors.
    function automatic logic op_is_valid(input logic [3:0] op);
        return (op <= OP_LAST_VALID);
    endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational core of the alu: computes next result, zero and error flags.
module alu_datapath
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [3:0]         op,
    input  logic               invalid_data,
    output logic [2*WIDTH-1:0] result_next,
    output logic               zero_next,
    output logic               error_next
);

    localparam int RW  = 2 * WIDTH;
    localparam int SHW = $clog2(RW);

    logic [RW-1:0]  a_s;
    logic [RW-1:0]  b_s;
    logic [SHW-1:0] shamt_s;
    logic [RW-1:0]  raw_s;
    logic           div_zero_s;

    assign a_s     = {{WIDTH{1'b0}}, in1};
    assign b_s     = {{WIDTH{1'b0}}, in2};
    assign shamt_s = in2[SHW-1:0];

    // Opcode decode; divide/modulo are gated on a zero divisor so no X is produced.
    always_comb begin
        raw_s      = {RW{1'b0}};
        div_zero_s = 1'b0;
        case (op_e'(op))
            OP_ADD: raw_s = a_s + b_s;
            OP_SUB: raw_s = a_s - b_s;
            OP_MUL: raw_s = a_s * b_s;
            OP_MOD: begin
                if (in2 == {WIDTH{1'b0}}) begin
                    div_zero_s = 1'b1;
                end else begin
                    raw_s = a_s % b_s;
                end
            end
            OP_DIV: begin
                if (in2 == {WIDTH{1'b0}}) begin
                    div_zero_s = 1'b1;
                end else begin
                    raw_s = a_s / b_s;
                end
            end
            OP_AND: raw_s = a_s & b_s;
            OP_OR:  raw_s = a_s | b_s;
            OP_XOR: raw_s = a_s ^ b_s;
            OP_SHL: raw_s = a_s << shamt_s;
            OP_SHR: raw_s = a_s >> shamt_s;
            default: raw_s = {RW{1'b0}};
        endcase
    end

    // Any error forces a zero result with the zero flag cleared.
    always_comb begin
        error_next = invalid_data | div_zero_s | ~op_is_valid(op);
        if (error_next) begin
            result_next = {RW{1'b0}};
            zero_next   = 1'b0;
        end else begin
            result_next = raw_s;
            zero_next   = (raw_s == {RW{1'b0}});
        end
    end

endmodule

// File: rtl/alu.sv
// Single-issue execute stage: combinational datapath followed by one output register.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    input  logic [3:0]         op,
    input  logic               invalid_data,
    output logic [2*WIDTH-1:0] out,
    output logic               zero,
    output logic               error
);

    logic [2*WIDTH-1:0] result_next_s;
    logic               zero_next_s;
    logic               error_next_s;

    alu_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .in1         (in1),
        .in2         (in2),
        .op          (op),
        .invalid_data(invalid_data),
        .result_next (result_next_s),
        .zero_next   (zero_next_s),
        .error_next  (error_next_s)
    );

    // Output register; reset discards whatever operation is presented that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out   <= {(2*WIDTH){1'b0}};
            zero  <= 1'b0;
            error <= 1'b0;
        end else begin
            out   <= result_next_s;
            zero  <= zero_next_s;
            error <= error_next_s;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu with hand-computed expected values.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [7:0]  in1;
    logic [7:0]  in2;
    logic [3:0]  op;
    logic        invalid_data;
    logic [15:0] out;
    logic        zero;
    logic        error;

    int compared;
    int mismatched;

    alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in1         (in1),
        .in2         (in2),
        .op          (op),
        .invalid_data(invalid_data),
        .out         (out),
        .zero        (zero),
        .error       (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] exp_out,
                         input logic exp_zero, input logic exp_err);
        compared = compared + 3;
        assert (out === exp_out) else begin
            mismatched++;
            $error("FAIL %s out: observed %h expected %h", tag, out, exp_out);
        end
        assert (zero === exp_zero) else begin
            mismatched++;
            $error("FAIL %s zero: observed %b expected %b", tag, zero, exp_zero);
        end
        assert (error === exp_err) else begin
            mismatched++;
            $error("FAIL %s error: observed %b expected %b", tag, error, exp_err);
        end
    endtask

    // Present an operation, let one edge pass, sample 1 time unit later.
    task automatic step(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic inv);
        op           = o;
        in1          = a;
        in2          = b;
        invalid_data = inv;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] b2b_exp [10];
    logic        b2b_zero [10];

    initial begin
        compared   = 0;
        mismatched = 0;

        b2b_exp[0] = 16'h00D8; b2b_exp[1] = 16'h00B2; b2b_exp[2] = 16'h0E9F;
        b2b_exp[3] = 16'h0007; b2b_exp[4] = 16'h000A; b2b_exp[5] = 16'h0001;
        b2b_exp[6] = 16'h00D7; b2b_exp[7] = 16'h00D6; b2b_exp[8] = 16'h0628;
        b2b_exp[9] = 16'h0018;
        for (int i = 0; i < 10; i++) b2b_zero[i] = 1'b0;

        rst = 1'b1;
        op = 4'h0; in1 = 8'hAA; in2 = 8'h01; invalid_data = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 16'h0000, 1'b0, 1'b0);

        rst = 1'b0;
        step(4'h0, 8'hAA, 8'h01, 1'b0);
        check("add_first", 16'h00AB, 1'b0, 1'b0);

        // Inputs changing between edges must not disturb the registered outputs.
        in1 = 8'h00; in2 = 8'h00; op = 4'hF; invalid_data = 1'b1;
        #3;
        check("hold", 16'h00AB, 1'b0, 1'b0);

        step(4'h1, 8'h0A, 8'h02, 1'b0); check("sub",      16'h0008, 1'b0, 1'b0);
        step(4'h2, 8'h04, 8'h02, 1'b0); check("mul",      16'h0008, 1'b0, 1'b0);
        step(4'h4, 8'h04, 8'h02, 1'b0); check("div",      16'h0002, 1'b0, 1'b0);
        step(4'h1, 8'h08, 8'h08, 1'b0); check("sub_zero", 16'h0000, 1'b1, 1'b0);
        step(4'h0, 8'hFF, 8'hFF, 1'b0); check("add_max",  16'h01FE, 1'b0, 1'b0);
        step(4'h2, 8'hFF, 8'hFF, 1'b0); check("mul_max",  16'hFE01, 1'b0, 1'b0);
        step(4'h1, 8'h00, 8'h01, 1'b0); check("sub_wrap", 16'hFFFF, 1'b0, 1'b0);
        step(4'h8, 8'hFF, 8'h1F, 1'b0); check("shl_15",   16'h8000, 1'b0, 1'b0);
        step(4'h9, 8'h80, 8'h17, 1'b0); check("shr_7",    16'h0001, 1'b0, 1'b0);
        step(4'h3, 8'h07, 8'h07, 1'b0); check("mod_zero", 16'h0000, 1'b1, 1'b0);

        step(4'h4, 8'h08, 8'h00, 1'b0); check("div_by0",  16'h0000, 1'b0, 1'b1);
        step(4'h4, 8'h08, 8'h00, 1'b1); check("div_inv",  16'h0000, 1'b0, 1'b1);
        step(4'h3, 8'h08, 8'h00, 1'b0); check("mod_by0",  16'h0000, 1'b0, 1'b1);
        step(4'h0, 8'h01, 8'h01, 1'b1); check("add_inv",  16'h0000, 1'b0, 1'b1);
        step(4'hF, 8'h01, 8'h01, 1'b0); check("op_f",     16'h0000, 1'b0, 1'b1);
        step(4'hA, 8'h00, 8'h00, 1'b0); check("op_a",     16'h0000, 1'b0, 1'b1);
        step(4'h0, 8'h00, 8'h00, 1'b0); check("add_zero", 16'h0000, 1'b1, 1'b0);

        // Back-to-back through all valid opcodes with one operand pair.
        for (int i = 0; i < 10; i++) begin
            step(4'(i), 8'hC5, 8'h13, 1'b0);
            check($sformatf("b2b_op%0d", i), b2b_exp[i], b2b_zero[i], 1'b0);
        end

        // Reset mid-stream discards the op presented with it.
        step(4'h0, 8'h10, 8'h20, 1'b0); check("pre_rst", 16'h0030, 1'b0, 1'b0);
        rst = 1'b1;
        step(4'h2, 8'h10, 8'h10, 1'b0); check("mid_rst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        step(4'h6, 8'hF0, 8'h0F, 1'b0); check("post_rst", 16'h00FF, 1'b0, 1'b0);
        step(4'h4, 8'h10, 8'h00, 1'b0); check("post_err", 16'h0000, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
